// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields plus a 32-bit immediate into an instruction word
// and streams legal words into IMEM at an auto-incrementing word address.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        fmt_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  input  logic              imem_stall_i,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [15:0]       count_o
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] FMT_I = 2'd0;
  localparam logic [1:0] FMT_S = 2'd1;
  localparam logic [1:0] FMT_B = 2'd2;
  localparam logic [1:0] FMT_U = 2'd3;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] nxt_addr_q, nxt_addr_d;

  logic              complete;
  logic              accept;
  logic              shift_case;
  logic              legal;
  logic              sext12_ok;
  logic              sext13_ok;
  logic [31:0]       packed_word;
  logic [ADDR_W-1:0] wr_addr;

  assign complete   = we_q & ~imem_stall_i;
  assign in_ready_o = ~start_i & (~we_q | ~imem_stall_i);
  assign accept     = in_valid_i & in_ready_o;

  // A write completing this edge frees its slot, so the new word goes one further.
  assign wr_addr = complete ? nxt_addr_q + ADDR_W'(1) : nxt_addr_q;

  assign shift_case = (fmt_i == FMT_I) & opcode_i[4] &
                      ((funct3_i == 3'b001) | (funct3_i == 3'b101));
  assign sext12_ok  = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign sext13_ok  = (&imm_i[31:12]) | ~(|imm_i[31:12]);

  // Field packing and immediate range check per format
  always_comb begin
    packed_word = '0;
    legal       = 1'b0;
    case (fmt_i)
      FMT_I: begin
        if (shift_case) begin
          packed_word = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
          legal       = ~(|imm_i[31:5]);
        end else begin
          packed_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
          legal       = sext12_ok;
        end
      end
      FMT_S: begin
        packed_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        legal       = sext12_ok;
      end
      FMT_B: begin
        packed_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
        legal       = sext13_ok & ~imm_i[0];
      end
      FMT_U: begin
        packed_word = {imm_i[31:12], rd_i, opcode_i};
        legal       = ~(|imm_i[11:0]);
      end
      default: begin
        packed_word = '0;
        legal       = 1'b0;
      end
    endcase
  end

  // Next-state for the output stage, address pointer, error and counter
  always_comb begin
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    count_d    = count_q;
    nxt_addr_d = nxt_addr_q;

    if (start_i) begin
      we_d       = 1'b0;
      addr_d     = start_addr_i;
      nxt_addr_d = start_addr_i;
      err_d      = 1'b0;
      err_addr_d = '0;
      count_d    = '0;
    end else begin
      if (complete) begin
        we_d       = 1'b0;
        nxt_addr_d = nxt_addr_q + ADDR_W'(1);
        count_d    = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
      end
      if (accept) begin
        if (legal) begin
          we_d    = 1'b1;
          addr_d  = wr_addr;
          wdata_d = packed_word;
        end else begin
          err_d = 1'b1;
          if (!err_q) begin
            err_addr_d = wr_addr;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      count_q    <= '0;
      nxt_addr_q <= BASE_ADDR;
    end else begin
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      count_q    <= count_d;
      nxt_addr_q <= nxt_addr_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign err_o        = err_q;
  assign err_addr_o   = err_addr_q;
  assign count_o      = count_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Packs decoded instruction fields plus a full 32-bit immediate back into a 32-bit RV32I instruction word. This is the inverse of the core's immediate generator.
- Writes each packed word into instruction memory at an auto-incrementing word address.
- Sits between the boot/debug loader and the IMEM write port.
- Checks each immediate against its format; bad entries are rejected and flagged instead of being silently truncated.

## Interface
Parameters:
- ADDR_W, 12, IMEM word-address width
- BASE_ADDR, 0, write address after reset

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- start_i  input  1  one-cycle pulse: restart the stream at start_addr_i
- start_addr_i  input  ADDR_W  first word address of the new stream
- in_valid_i  input  1  field bundle valid
- in_ready_o  output  1  bundle accepted on an edge where in_valid_i & in_ready_o
- fmt_i  input  2  format: 0 I, 1 S, 2 B, 3 U (same coding as the immediate-select mux)
- opcode_i  input  7  opcode field
- funct3_i  input  3  funct3 field
- funct7_i  input  7  funct7 field; used only for immediate shifts
- rd_i, rs1_i, rs2_i  input  5 each  register fields
- imm_i  input  32  immediate as the decoder would produce it (sign-extended, byte offset)
- imem_we_o  output  1  write strobe
- imem_addr_o  output  ADDR_W  write word address
- imem_wdata_o  output  32  instruction word
- imem_stall_i  input  1  IMEM cannot take the write this cycle
- err_o  output  1  sticky: set on a range violation
- err_addr_o  output  ADDR_W  address of the first rejected entry
- count_o  output  16  words written since the last start; saturates at 0xFFFF

## Operation
Packing by fmt_i (fields not listed are zero):
- I: {imm[11:0], rs1, funct3, rd, opcode}.
- I, immediate-shift case (opcode_i[4]=1 and funct3 is 001 or 101): {funct7, imm[4:0], rs1, funct3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- U: {imm[31:12], rd, opcode}.

Legality checks. An entry is legal only if:
- I/S: imm[31:11] is all equal.
- Immediate shift: imm[31:5] == 0.
- B: imm[31:12] is all equal and imm[0] == 0.
- U: imm[11:0] == 0.

Illegal entry:
- The bundle is consumed.
- No write is issued and the address is not advanced.
- err_o is set.
- err_addr_o captures the current write address, only if err_o was previously 0.

Address handling:
- The internal next address (nxt_addr) loads BASE_ADDR on reset and start_addr_i on start_i.
- nxt_addr advances by 1 when a write completes (imem_we_o & ~imem_stall_i).
- It wraps modulo 2^ADDR_W with no error.

start_i:
- Clears err_o, err_addr_o (to 0) and count_o.
- Drops any pending write (imem_we_o = 0 next cycle).
- Has priority over a simultaneous input handshake; in_ready_o = 0 while start_i = 1.

## Timing
Reset values:
- imem_we_o = 0, imem_addr_o = BASE_ADDR, imem_wdata_o = 0.
- err_o = 0, err_addr_o = 0, count_o = 0.
- in_ready_o = 1.

Output stage is a single register stage:
- in_ready_o = ~start_i & (~imem_we_o | ~imem_stall_i). This is combinational, so back-to-back accepts sustain 1 word/cycle.
- Latency is 1: after a legal bundle is accepted at edge N, imem_we_o/addr/wdata are valid from edge N.
- While imem_stall_i = 1, imem_we_o, imem_addr_o and imem_wdata_o hold stable.

Completion and counting:
- count_o increments on each completed write.
- When no bundle is accepted, imem_we_o drops to 0 the cycle after completion.

Reset mid-stall: outputs return immediately to their reset values and the pending word is lost.

## Test plan
- I-type:
  - addi x1,x0,-1 (fmt 0, op 0010011, f3 0, rd 1, imm 0xFFFFFFFF), start_addr 0x010 -> next cycle: we = 1, addr 0x010, wdata 0xFFF00093.
  - srai x1,x1,3 (f3 101, funct7 0100000, imm 3) -> 0x4030D093 at 0x011.
- S/B/U back-to-back, no stall:
  - sw x2,8(x3) -> 0x0021A423.
  - beq x0,x0,-4 (imm 0xFFFFFFFC) -> 0xFE000EE3.
  - lui x5,0x12345 (imm 0x12345000) -> 0x123452B7.
  - Addresses consecutive, count_o = 3.
- Illegal entries:
  - U with imm 0x00000001 -> no write, err_o = 1, err_addr_o = current address.
  - A following B with imm 3 -> rejected, err_addr_o unchanged.
  - A following legal entry -> written at the same address.
- Stall: hold imem_stall_i for 3 cycles on a write -> we/addr/wdata stable, in_ready_o = 0; on release the address advances by exactly 1.
- Wrap: start_addr 2^ADDR_W-1, two legal entries -> addresses 0xFFF then 0x000, err_o = 0.
- Control corner cases:
  - start_i during a stalled write -> write dropped, count_o = 0, err_o cleared, next word written to the new start_addr.
  - rst_ni low mid-stream -> all outputs at reset values asynchronously.
